spi_slave_if: RTL

- Synthesizable SPI responder (target/slave) for mode 0 (CPOL=0, CPHA=0), MSB first, fixed-length frames.
- Acts as the far end of the SoC SPI master (sclk/cs/mosi/miso). Used as an on-chip peer for loopback tests and as a reusable peripheral front end.
- All SPI inputs are oversampled on the system clock, so there is a single clock domain.
- Exposes a one-entry TX holding buffer with a valid/ready handshake, and an RX word output with a one-cycle valid pulse.

---
 rtl/spi_slave_if.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder (MSB first, fixed DATA_W-bit frames) with oversampled
// inputs, a one-entry TX holding buffer and a one-cycle RX valid pulse.
module spi_slave_if #(
    parameter int                DATA_W      = 32,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = 32'h0000_0000
) (
    input  logic              clk_top,
    input  logic              reset,
    input  logic              sclk_in,
    input  logic              cs_in,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_abort,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_q, cs_q;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CNT_W-1:0]       bit_cnt;
    logic                   wrap;
    // Both shifters hold DATA_W-1 bits: the bit on the wire lives in miso_out,
    // and the last received bit comes straight from mosi_s.
    logic [DATA_W-2:0]      tx_sh;
    logic [DATA_W-2:0]      rx_sh;
    logic [DATA_W-1:0]      buf_q;
    logic                   buf_full;
    logic                   rx_pend;
    logic                   load;
    logic [DATA_W-1:0]      load_word;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    assign tx_ready  = ~buf_full;
    assign busy      = (state == SHIFT);

    // Synchronizers preset to the idle bus (sclk low, cs high) so leaving
    // reset never fakes a select edge.
    always_ff @(posedge clk_top) begin
        // NOTE: synchronous reset is tested inside the clocked block; every
        // register here is a flop that must reset, so none is left out.
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        load      = 1'b0;
        load_word = buf_full ? buf_q : IDLE_WORD;
        case (state)
            IDLE:    load = cs_fall;
            SHIFT:   load = !cs_rise && !sclk_rise && sclk_fall && wrap;
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_top) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            wrap        <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            miso_out    <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_pend     <= 1'b0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= rx_pend;
            rx_pend     <= 1'b0;
            frame_abort <= 1'b0;
            tx_underrun <= 1'b0;

            // A handshake can only happen while empty, so a simultaneous load
            // takes IDLE_WORD and the new word stays buffered.
            if (tx_valid && tx_ready) begin
                buf_q    <= tx_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (load) begin
                tx_sh       <= load_word[DATA_W-2:0];
                miso_out    <= load_word[DATA_W-1];
                tx_underrun <= !buf_full;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        wrap    <= 1'b0;
                        rx_sh   <= '0;
                        miso_oe <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bit_cnt     <= '0;
                        wrap        <= 1'b0;
                        rx_sh       <= '0;
                        miso_oe     <= 1'b0;
                        miso_out    <= 1'b0;
                        frame_abort <= (bit_cnt != '0);
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[DATA_W-3:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            rx_data <= {rx_sh, mosi_s};
                            rx_pend <= 1'b1;
                            bit_cnt <= '0;
                            wrap    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (wrap) begin
                            wrap <= 1'b0;
                        end else begin
                            tx_sh    <= {tx_sh[DATA_W-3:0], 1'b0};
                            miso_out <= tx_sh[DATA_W-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
